// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer
// Purpose  : Sequencer for a coefficient-ROM / sample-RAM multiply-accumulate
//            datapath. While idle it passes host sample writes straight to the
//            sample RAM. On a start request it walks taps 0..NUM_TAPS-1 over
//            both memories, accumulates ram_q*rom_q, and presents the sum with
//            a one-cycle valid pulse and a level done indicator. A pacing
//            divider optionally slows the tap rate.
// Ports    : clk, rst                 - clock, async active-high reset
//            i_start, i_abort         - run request / run termination
//            i_load_valid/index/data  - host sample write channel
//            o_load_ready             - host writes accepted (IDLE or DONE)
//            o_ram_addr/wdata/we      - sample RAM write/read port
//            o_rom_addr               - coefficient ROM address
//            i_ram_q, i_rom_q         - memory read data (RD_LAT cycles late)
//            o_result, o_result_valid - last completed sum, completion pulse
//            o_busy, o_done_led       - run in progress, completed-run level
// Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_TAPS = 10,
  parameter int ACC_W    = 20,
  parameter int RD_LAT   = 1,
  parameter int STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_load_valid,
  input  logic [ADDR_W-1:0] i_load_index,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_ram_q,
  input  logic [DATA_W-1:0] i_rom_q,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_result_valid,
  output logic              o_busy,
  output logic              o_done_led
);

  // One shared counter times both the WAIT and PACE phases; it only has to
  // reach the larger of RD_LAT-2 and STEP_DIV-2.
  localparam int c_CNT_MAX = (RD_LAT > STEP_DIV) ? RD_LAT : STEP_DIV;
  localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);

  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'((RD_LAT   > 1) ? RD_LAT   - 2 : 0);
  localparam logic [c_CNT_W-1:0] c_PACE_LAST = c_CNT_W'((STEP_DIV > 1) ? STEP_DIV - 2 : 0);
  localparam logic [ADDR_W-1:0]  c_LAST_TAP  = ADDR_W'(NUM_TAPS - 1);
  localparam bit                 c_HAS_WAIT  = (RD_LAT > 1);
  localparam bit                 c_HAS_PACE  = (STEP_DIV > 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_PACE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_result;
  logic                r_result_valid;
  logic [ADDR_W-1:0]   r_tap;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                w_host;
  logic                w_last;
  logic                w_run_start;
  logic                w_acc_en;
  logic                w_finish;
  logic                w_cnt_clr;
  logic                w_cnt_inc;

  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_acc_next;

  // --------------------------------------------------------------------------
  // Datapath: unsigned full-width product, fitted to the accumulator width.
  // The running sum wraps naturally modulo 2^ACC_W.
  // --------------------------------------------------------------------------
  assign w_prod = {{DATA_W{1'b0}}, i_ram_q} * {{DATA_W{1'b0}}, i_rom_q};

  generate
    if (ACC_W > 2*DATA_W) begin : g_prod_zext
      assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
    end else if (ACC_W == 2*DATA_W) begin : g_prod_same
      assign w_prod_ext = w_prod;
    end else begin : g_prod_trunc
      assign w_prod_ext = w_prod[ACC_W-1:0];
    end
  endgenerate

  assign w_acc_next = r_acc + w_prod_ext;
  assign w_last     = (r_tap == c_LAST_TAP);
  assign w_host     = (r_state == S_IDLE) || (r_state == S_DONE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_run_start  = 1'b0;
    w_acc_en     = 1'b0;
    w_finish     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        // A host write wins over a simultaneous start; the start is dropped.
        if (i_load_valid) begin
          w_state_next = S_IDLE;
        end else if (i_start) begin
          w_run_start  = 1'b1;
          w_state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_cnt_clr = 1'b1;
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (c_HAS_WAIT) begin
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_ACC;
        end
      end

      S_WAIT: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == c_WAIT_LAST) begin
          w_state_next = S_ACC;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      S_ACC: begin
        w_cnt_clr = 1'b1;
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_acc_en = 1'b1;
          if (w_last) begin
            w_finish     = 1'b1;
            w_state_next = S_DONE;
          end else if (c_HAS_PACE) begin
            w_state_next = S_PACE;
          end else begin
            w_state_next = S_ISSUE;
          end
        end
      end

      S_PACE: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == c_PACE_LAST) begin
          w_state_next = S_ISSUE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulator, tap index, result and phase counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc          <= '0;
      r_tap          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_result_valid <= w_finish;

      if (w_run_start) begin
        r_acc <= '0;
        r_tap <= '0;
      end

      if (w_acc_en) begin
        r_acc <= w_acc_next;
        // The tap index holds on the last tap so it never passes NUM_TAPS-1.
        if (!w_last) begin
          r_tap <= r_tap + ADDR_W'(1);
        end
      end

      if (w_finish) begin
        r_result <= w_acc_next;
      end

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The tap register doubles as the read address, so the address is
  // stable from ISSUE through WAIT and ACC.
  // --------------------------------------------------------------------------
  assign o_load_ready   = w_host;
  assign o_ram_we       = w_host & i_load_valid;
  assign o_ram_addr     = w_host ? i_load_index : r_tap;
  assign o_ram_wdata    = i_load_data;
  assign o_rom_addr     = r_tap;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = ~w_host;
  assign o_done_led     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_sequencer
// Purpose  : Self-checking bench for mac_sequencer. Three instances cover the
//            basic sum, accumulator wrap and paced/two-cycle-latency configs.
//            Expected sums and completion cycles are queued when a run is
//            started and compared when result_valid is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Shared host stimulus, steered to one instance by sel.
  logic [2:0] sel        = 3'b000;
  logic       start      = 1'b0;
  logic       abort      = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_index = 8'd0;
  logic [7:0] load_data  = 8'd0;

  logic [7:0]  ram_addr  [3];
  logic [7:0]  ram_wdata [3];
  logic [7:0]  rom_addr  [3];
  logic [7:0]  ram_q     [3];
  logic [7:0]  rom_q     [3];
  logic        we        [3];
  logic        rdy       [3];
  logic        vld       [3];
  logic        busy      [3];
  logic        led       [3];
  logic [19:0] res       [3];
  logic [15:0] res_w16;
  assign res[1] = {4'd0, res_w16};

  logic [7:0] shadow [3][256];

  typedef struct {
    int          inst;
    logic [19:0] val;
    int          cyc;
  } sb_t;
  sb_t sb[$];

  function automatic int ntaps(int g);
    return (g == 1) ? 2 : 3;
  endfunction
  function automatic int accw(int g);
    return (g == 1) ? 16 : 20;
  endfunction
  function automatic int rdlat(int g);
    return (g == 2) ? 2 : 1;
  endfunction
  function automatic int stepdiv(int g);
    return (g == 2) ? 4 : 1;
  endfunction
  function automatic logic [7:0] rom_fn(int g, logic [7:0] a);
    return (g == 1) ? 8'd255 : a + 8'd1;
  endfunction

  function automatic logic [19:0] exp_sum(int g);
    int s = 0;
    for (int i = 0; i < ntaps(g); i++)
      s += int'(shadow[g][i]) * int'(rom_fn(g, 8'(i)));
    s = s % (1 << accw(g));
    return 20'(s);
  endfunction

  function automatic int exp_lat(int g);
    return 1 + ntaps(g) * (rdlat(g) + 1) + (ntaps(g) - 1) * (stepdiv(g) - 1);
  endfunction

  // --------------------------------------------------------------------------
  // DUTs
  // --------------------------------------------------------------------------
  mac_sequencer #(.DATA_W(8), .ADDR_W(8), .NUM_TAPS(3), .ACC_W(20), .RD_LAT(1), .STEP_DIV(1)) u_basic (
    .clk(clk), .rst(rst),
    .i_start(start & sel[0]), .i_abort(abort & sel[0]),
    .i_load_valid(load_valid & sel[0]), .i_load_index(load_index), .i_load_data(load_data),
    .o_load_ready(rdy[0]), .o_ram_addr(ram_addr[0]), .o_ram_wdata(ram_wdata[0]), .o_ram_we(we[0]),
    .o_rom_addr(rom_addr[0]), .i_ram_q(ram_q[0]), .i_rom_q(rom_q[0]),
    .o_result(res[0]), .o_result_valid(vld[0]), .o_busy(busy[0]), .o_done_led(led[0])
  );

  mac_sequencer #(.DATA_W(8), .ADDR_W(8), .NUM_TAPS(2), .ACC_W(16), .RD_LAT(1), .STEP_DIV(1)) u_wrap (
    .clk(clk), .rst(rst),
    .i_start(start & sel[1]), .i_abort(abort & sel[1]),
    .i_load_valid(load_valid & sel[1]), .i_load_index(load_index), .i_load_data(load_data),
    .o_load_ready(rdy[1]), .o_ram_addr(ram_addr[1]), .o_ram_wdata(ram_wdata[1]), .o_ram_we(we[1]),
    .o_rom_addr(rom_addr[1]), .i_ram_q(ram_q[1]), .i_rom_q(rom_q[1]),
    .o_result(res_w16), .o_result_valid(vld[1]), .o_busy(busy[1]), .o_done_led(led[1])
  );

  mac_sequencer #(.DATA_W(8), .ADDR_W(8), .NUM_TAPS(3), .ACC_W(20), .RD_LAT(2), .STEP_DIV(4)) u_pace (
    .clk(clk), .rst(rst),
    .i_start(start & sel[2]), .i_abort(abort & sel[2]),
    .i_load_valid(load_valid & sel[2]), .i_load_index(load_index), .i_load_data(load_data),
    .o_load_ready(rdy[2]), .o_ram_addr(ram_addr[2]), .o_ram_wdata(ram_wdata[2]), .o_ram_we(we[2]),
    .o_rom_addr(rom_addr[2]), .i_ram_q(ram_q[2]), .i_rom_q(rom_q[2]),
    .o_result(res[2]), .o_result_valid(vld[2]), .o_busy(busy[2]), .o_done_led(led[2])
  );

  // --------------------------------------------------------------------------
  // Memory models: synchronous RAM/ROM with 1 or 2 cycle read latency
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_mem
    logic [7:0] mem [256];
    logic [7:0] q1r, q2r, q1o, q2o;
    always @(posedge clk) begin
      if (we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      q1r <= mem[ram_addr[g]];
      q1o <= rom_fn(g, rom_addr[g]);
      q2r <= q1r;
      q2o <= q1o;
    end
    assign ram_q[g] = (g == 2) ? q2r : q1r;
    assign rom_q[g] = (g == 2) ? q2o : q1o;
  end

  // --------------------------------------------------------------------------
  // Scoreboard monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (vld[g] === 1'b1) begin
        checks++;
        if (sb.size() == 0 || sb[0].inst != g) begin
          errors++;
          $display("FAIL unexpected_valid inst=%0d cycle=%0d result=%0d", g, cyc, res[g]);
        end else begin
          if (res[g] !== sb[0].val || cyc != sb[0].cyc) begin
            errors++;
            $display("FAIL result inst=%0d got %0d at cycle %0d, want %0d at cycle %0d",
                     g, res[g], cyc, sb[0].val, sb[0].cyc);
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int g, input logic [7:0] idx, input logic [7:0] d);
    sel        = 3'(1 << g);
    load_valid = 1'b1;
    load_index = idx;
    load_data  = d;
    #1;
    checks++;
    if (we[g] !== 1'b1 || ram_addr[g] !== idx) begin
      errors++;
      $display("FAIL load_passthru inst=%0d we=%b addr=%0d, want we=1 addr=%0d", g, we[g], ram_addr[g], idx);
    end
    tick();
    load_valid = 1'b0;
    load_index = 8'd0;
    shadow[g][idx] = d;
  endtask

  task automatic run(input int g, input bit push);
    sb_t e;
    sel   = 3'(1 << g);
    start = 1'b1;
    if (push) begin
      e.inst = g;
      e.val  = exp_sum(g);
      e.cyc  = cyc + exp_lat(g);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout pending=%0d after %0d cycles, want 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    run(0, 1'b0);
    tick();
    tick();                       // now in ISSUE of tap 1
    checks++;
    if (rom_addr[0] !== 8'd1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset rom_addr=%0d busy=%b, want 1 1", rom_addr[0], busy[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || led[0] !== 1'b0 || vld[0] !== 1'b0 || res[0] !== 20'd0 ||
        rdy[0] !== 1'b1 || we[0] !== 1'b0 || rom_addr[0] !== 8'd0 || ram_addr[0] !== 8'd0) begin
      errors++;
      $display("FAIL reset_values busy=%b led=%b vld=%b res=%0d rdy=%b we=%b rom=%0d ram=%0d, want 0 0 0 0 1 0 0 0",
               busy[0], led[0], vld[0], res[0], rdy[0], we[0], rom_addr[0], ram_addr[0]);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load(0, 8'd0, 8'd2);
    load(0, 8'd1, 8'd3);
    load(0, 8'd2, 8'd4);
    run(0, 1'b1);
    wait_done(40);
    checks++;
    if (led[0] !== 1'b1 || busy[0] !== 1'b0 || vld[0] !== 1'b0 || res[0] !== 20'd20) begin
      errors++;
      $display("FAIL basic_done led=%b busy=%b vld=%b res=%0d, want 1 0 0 20", led[0], busy[0], vld[0], res[0]);
    end
  endtask

  task automatic test_wrap();
    load(1, 8'd0, 8'd255);
    load(1, 8'd1, 8'd255);
    run(1, 1'b1);
    wait_done(40);
    checks++;
    if (res[1] !== 20'd64514) begin
      errors++;
      $display("FAIL wrap res=%0d, want 64514", res[1]);
    end
  endtask

  task automatic test_pacing();
    load(2, 8'd0, 8'd5);
    load(2, 8'd1, 8'd6);
    load(2, 8'd2, 8'd7);
    run(2, 1'b1);
    wait_done(60);
    checks++;
    if (res[2] !== 20'd38 || led[2] !== 1'b1) begin
      errors++;
      $display("FAIL pacing res=%0d led=%b, want 38 1", res[2], led[2]);
    end
  endtask

  task automatic test_host_busy();
    run(0, 1'b1);
    load_valid = 1'b1;
    load_index = 8'd0;
    load_data  = 8'd99;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (we[0] !== 1'b0 || rdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL busy_load we=%b rdy=%b, want 0 0", we[0], rdy[0]);
      end
      tick();
    end
    load_valid = 1'b0;
    wait_done(40);
    checks++;
    if (g_mem[0].mem[0] !== 8'd2) begin
      errors++;
      $display("FAIL busy_ram mem0=%0d, want 2", g_mem[0].mem[0]);
    end
  endtask

  task automatic test_start_load();
    // First pass leaves DONE, second pass is from plain IDLE.
    for (int k = 0; k < 2; k++) begin
      sel        = 3'b001;
      start      = 1'b1;
      load_valid = 1'b1;
      load_index = 8'(5 + k);
      load_data  = 8'(7 + k);
      tick();
      start      = 1'b0;
      load_valid = 1'b0;
      shadow[0][5 + k] = 8'(7 + k);
      tick();
      checks++;
      if (busy[0] !== 1'b0 || led[0] !== 1'b0 || g_mem[0].mem[5 + k] !== 8'(7 + k)) begin
        errors++;
        $display("FAIL start_load k=%0d busy=%b led=%b mem=%0d, want 0 0 %0d",
                 k, busy[0], led[0], g_mem[0].mem[5 + k], 7 + k);
      end
    end
  endtask

  task automatic test_abort();
    run(0, 1'b0);
    tick();                       // ISSUE tap1 follows
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0 || rdy[0] !== 1'b1 || res[0] !== 20'd20 || led[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%b rdy=%b res=%0d led=%b, want 0 1 20 0", busy[0], rdy[0], res[0], led[0]);
    end
    repeat (10) tick();
    run(0, 1'b1);
    wait_done(40);
  endtask

  task automatic test_back_to_back();
    // Start straight from DONE, with a changed sample so the sum differs.
    load(2, 8'd1, 8'd10);
    run(2, 1'b1);
    wait_done(60);
    run(2, 1'b1);
    wait_done(60);
    checks++;
    if (res[2] !== 20'd46) begin
      errors++;
      $display("FAIL back_to_back res=%0d, want 46", res[2]);
    end
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_wrap();
    test_pacing();
    test_host_busy();
    test_start_load();
    test_abort();
    test_back_to_back();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Controller for the coefficient-ROM / sample-RAM multiply-accumulate datapath. In IDLE it passes host sample writes through to the sample RAM. On start it reads taps 0..NUM_TAPS-1 from both memories, accumulates ram_q*rom_q, and presents the sum with a valid pulse and a done indicator. An optional pacing divider sets the tap rate, so the same block serves both the visible board demo and full-speed operation.

Parameters:
DATA_W, 8, width of sample and coefficient words
ADDR_W, 8, width of memory address
NUM_TAPS, 10, taps per run (legal range 1..2^ADDR_W)
ACC_W, 20, accumulator/result width
RD_LAT, 1, memory read latency in cycles from address to q (1 or 2)
STEP_DIV, 1, cycles between successive tap issues (1 = back-to-back)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle run request, sampled in IDLE/DONE only
abort  in  1  terminate run, return to IDLE without result
load_valid  in  1  host sample write strobe
load_index  in  ADDR_W  host sample address
load_data  in  DATA_W  host sample data
load_ready  out  1  high when host writes are accepted (IDLE or DONE)
ram_addr  out  ADDR_W  sample RAM address
ram_wdata  out  DATA_W  sample RAM write data
ram_we  out  1  sample RAM write enable
rom_addr  out  ADDR_W  coefficient ROM address
ram_q  in  DATA_W  sample RAM read data
rom_q  in  DATA_W  coefficient ROM read data
result  out  ACC_W  last completed sum
result_valid  out  1  one-cycle pulse on completion
busy  out  1  high from run accept until DONE/IDLE
done_led  out  1  level, high in DONE

Behaviour:
- Reset (async, active-high) sets: state=IDLE, result=0, result_valid=0, busy=0, done_led=0, ram_we=0, ram_addr=rom_addr=0, accumulator=0, tap=0, pace counter=0.
- States: IDLE, ISSUE, WAIT, ACC, PACE, DONE.
- IDLE/DONE:
  - load_ready=1.
  - ram_addr=load_index, ram_wdata=load_data, ram_we=load_valid (combinational pass-through).
  - A load_valid in DONE returns the state to IDLE (done_led drops) after the write.
- Priority in IDLE/DONE: a load_valid with start in the same cycle performs the write and drops the start; the host must re-assert start.
- start accepted: acc=0, tap=0, busy=1, done_led=0, next state ISSUE.
- ISSUE (1 cycle): ram_addr=rom_addr=tap, ram_we=0. The address stays registered and stable through WAIT and ACC.
- WAIT: RD_LAT-1 cycles. It is skipped when RD_LAT=1.
- ACC (1 cycle): acc <= acc + ram_q*rom_q.
  - The product is unsigned and 2*DATA_W bits, zero-extended.
  - The sum wraps modulo 2^ACC_W with no saturation.
- After ACC:
  - If tap==NUM_TAPS-1: go to DONE, result<=acc_next, result_valid=1 for the first DONE cycle only, busy=0, done_led=1.
  - Otherwise tap+=1 and go to PACE, or straight to ISSUE if STEP_DIV=1.
- PACE: waits STEP_DIV-1 cycles, then ISSUE. Tap issue cycles are spaced exactly (RD_LAT+1) + (STEP_DIV-1) apart, with a minimum of RD_LAT+1.
- Latency with STEP_DIV=1: start sampled at edge k gives result_valid at cycle k+1+NUM_TAPS*(RD_LAT+1).
- start while busy: ignored.
- load_valid while busy: ignored, load_ready=0, ram_we=0.
- abort:
  - In any run state: next state IDLE, busy=0, result and done_led unchanged (done_led is already 0), no result_valid.
  - In IDLE/DONE: abort is a no-op.
- tap wrap: tap never exceeds NUM_TAPS-1. When NUM_TAPS=2^ADDR_W the last address is all-ones and the run ends without wrapping.
- result holds its value until the next completed run.

Test Plan:
- Reset values: assert rst mid-ISSUE of a run -> all outputs return to their reset values immediately (async), state IDLE, load_ready=1.
- Basic sum: NUM_TAPS=3, RD_LAT=1, STEP_DIV=1, RAM loaded {2,3,4}, ROM {1,2,3}, start at cycle 0 -> ISSUE at cycles 1/3/5, result=20 with result_valid at cycle 7, done_led=1, busy=0.
- Wrap: ACC_W=16, NUM_TAPS=2, samples {255,255}, coefficients {255,255} -> result=64514 (130050 mod 65536).
- Pacing: STEP_DIV=4, RD_LAT=2, NUM_TAPS=3 -> tap issues 6 cycles apart, result_valid 1+3*3+2*3=16 cycles after start.
- Host interaction:
  - load_valid during busy -> ram_we stays 0 and the RAM is unchanged.
  - start+load_valid together in IDLE -> write occurs, no run begins.
  - load_valid in DONE -> done_led clears.
- Abort: abort during tap 1 of a 3-tap run -> IDLE next cycle, no result_valid, result keeps its prior value (20); a fresh start then completes normally.
